apb_uart: RTL and testbench
===========================

Name: apb_uart

Overview:
- APB slave UART that sits directly downstream of the AXI-to-APB bridge. It consumes the bridge's PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PRDATA/PREADY/PSLVERR.
- Provides an 8-N-1 serial transmitter with a TX FIFO, a serial receiver with a single holding register, a programmable baud divisor and an interrupt line.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries (power of two, ≥2).
- DEFAULT_DIV, 16'd434, reset value of the baud divisor in ACLK cycles per bit.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1=write, 0=read
- PADDR  in  32  byte address; only [4:2] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error, valid with PREADY
- uart_txd  out  1  serial out, idle high
- uart_rxd  in  1  serial in, asynchronous
- irq  out  1  level interrupt

Behaviour:
- Clock and reset: one clock, ACLK; reset ARESETn is asynchronous, active-low.
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, uart_txd=1, irq=0. FIFO empty, rx_valid=0, error flags=0, CTRL=0x3, BAUD=DEFAULT_DIV.
- Reset mid-frame aborts the frame immediately; uart_txd returns to 1.
- APB timing, one wait state:
  - PREADY is registered. It goes to 1 in the cycle after PSEL&PENABLE&!PREADY is seen, and returns to 0 the next cycle.
  - The transfer completes when PSEL&PENABLE&PREADY. All side effects (push, pop, register write) happen on that edge only, exactly once per transfer.
  - PRDATA and PSLVERR are registered alongside PREADY. PRDATA=0 on writes.
- Register map (PADDR[4:2]):
  - 0 TXDATA (W): PWDATA[7:0] is pushed to the FIFO. If the FIFO is full, the byte is dropped and PSLVERR=1. Reads return 0.
  - 1 RXDATA (R): returns {24'b0, rx_byte} and clears rx_valid. If rx_valid=0, returns 0 with PSLVERR=1. Writes are ignored.
  - 2 STATUS (R): bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_overrun, bit4 tx_busy, bit5 frame_err. Write 1 to bit3 or bit5 clears that flag; other bits are ignored.
  - 3 CTRL (RW, bits[3:0]): bit0 tx_en, bit1 rx_en, bit2 rx_ie, bit3 tx_ie.
  - 4 BAUD (RW, bits[15:0]): a written value below 4 is clamped to 4.
  - 5–7: PSLVERR=1, PRDATA=0, no side effect.
- TX FIFO: circular buffer with read/write pointers and a count.
  - A push and a pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM (TX_IDLE, TX_START, TX_DATA, TX_STOP):
  - Leaves TX_IDLE when tx_en=1 and the FIFO is not empty; it pops one byte at that moment.
  - Each state lasts BAUD cycles via a down-counter. Data is sent LSB first over 8 bits.
  - From TX_STOP it goes to TX_START directly if the FIFO is non-empty and tx_en=1, otherwise to TX_IDLE.
  - tx_busy = state≠TX_IDLE.
  - Clearing tx_en mid-frame finishes the current frame.
  - A BAUD change takes effect at the next bit boundary.
- RX:
  - uart_rxd passes through a 2-flop synchronizer.
  - RX FSM (RX_IDLE, RX_START, RX_DATA, RX_STOP), active only when rx_en=1.
  - A falling edge in RX_IDLE enters RX_START. The line is re-checked after BAUD/2 cycles; if it is high, return to RX_IDLE (glitch).
  - Then one sample every BAUD cycles: 8 data bits, LSB first, then the stop bit.
  - On the stop sample:
    - Stop=0 sets frame_err; the byte is still delivered.
    - If rx_valid=0, load rx_byte and set rx_valid=1.
    - If rx_valid=1, set rx_overrun and discard the new byte.
  - A pop by an RXDATA read in the same cycle as a new-byte load: the load wins and rx_valid stays 1.
- irq is registered: (rx_valid&rx_ie) | (tx_empty&tx_ie&!tx_busy).

Test Plan:
- Reset, then read STATUS → PRDATA=0x02, PSLVERR=0; read BAUD → 434; uart_txd=1.
- BAUD=8, write TXDATA 0xA5 → PREADY high exactly one cycle after the first PENABLE cycle. uart_txd sends 0, then 1,0,1,0,0,1,0,1, then 1, each for 8 cycles; STATUS.tx_busy=1 during the frame.
- Nine TXDATA writes with tx_en=0 → writes 1–8 PSLVERR=0, the 9th PSLVERR=1; STATUS=0x01. Set tx_en=1 → exactly 8 frames go out back-to-back.
- Drive 0x3C on uart_rxd at BAUD=8 → STATUS.rx_valid=1, irq=1 when rx_ie=1. Read RXDATA → 0x3C; read again → 0, PSLVERR=1.
- Two bytes received with no read in between, the second having stop=0 → STATUS=0x2E (tx_empty, rx_valid, overrun, frame_err), RXDATA=first byte. Write STATUS 0x28 → bits 3 and 5 cleared.
- Read PADDR 0x1C → PSLVERR=1, PRDATA=0. Deassert ARESETn mid-TX-frame → uart_txd=1 immediately, FIFO empty.

Source files
------------

// File: rtl/apb_uart_if.sv
// APB slave port bundle for the UART.
// The bridge drives the request side, the UART returns data, ready and error.
interface apb_uart_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_uart.sv
// APB UART: 8-N-1 transmitter with FIFO, receiver with holding register,
// programmable baud divisor and level interrupt.
module apb_uart #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    apb_uart_if.slave  apb,
    output logic       uart_txd,
    input  logic       uart_rxd,
    output logic       irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [2:0]  addr;
    logic        access, done;
    logic [3:0]  ctrl;
    logic [15:0] baud;
    logic [31:0] rdata;
    logic        err;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          tx_full, tx_empty, push, tx_pop, tx_busy;

    tx_state_t   tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;

    rx_state_t   rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_byte;
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_valid, rx_overrun, frame_err;
    logic        rx_stop_hit, rx_pop, clr_ovr, clr_fe;

    logic unused_bits;
    assign unused_bits = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA[31:16]};

    assign addr   = apb.PADDR[4:2];
    assign access = apb.PSEL & apb.PENABLE & ~apb.PREADY;
    assign done   = apb.PSEL & apb.PENABLE & apb.PREADY;

    assign tx_full  = (count == FULL_CNT);
    assign tx_empty = (count == '0);
    assign tx_busy  = (tx_state != TX_IDLE);
    assign push     = done & apb.PWRITE & (addr == 3'd0) & ~tx_full;
    assign tx_pop   = ((tx_state == TX_IDLE) ||
                       (tx_state == TX_STOP && tx_cnt == '0)) &&
                      ctrl[0] && !tx_empty;

    assign rx_pop  = done & ~apb.PWRITE & (addr == 3'd1);
    assign clr_ovr = done & apb.PWRITE & (addr == 3'd2) & apb.PWDATA[3];
    assign clr_fe  = done & apb.PWRITE & (addr == 3'd2) & apb.PWDATA[5];
    assign rx_stop_hit = ctrl[1] && (rx_state == RX_STOP) && (rx_cnt == '0);

    always_comb begin
        rdata = '0;
        err   = 1'b0;
        case (addr)
            3'd0: err = apb.PWRITE & tx_full;
            3'd1: if (!apb.PWRITE) begin
                err   = ~rx_valid;
                rdata = rx_valid ? {24'b0, rx_byte} : '0;
            end
            3'd2: if (!apb.PWRITE)
                rdata = {26'b0, frame_err, tx_busy, rx_overrun,
                         rx_valid, tx_empty, tx_full};
            3'd3: if (!apb.PWRITE) rdata = {28'b0, ctrl};
            3'd4: if (!apb.PWRITE) rdata = {16'b0, baud};
            default: err = 1'b1;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            apb.PREADY  <= 1'b0;
            apb.PRDATA  <= '0;
            apb.PSLVERR <= 1'b0;
            ctrl        <= 4'h3;
            baud        <= DEFAULT_DIV;
            irq         <= 1'b0;
        end else begin
            apb.PREADY  <= access;
            apb.PRDATA  <= access ? rdata : '0;
            apb.PSLVERR <= access & err;
            if (done && apb.PWRITE && addr == 3'd3)
                ctrl <= apb.PWDATA[3:0];
            // Divisors below 4 would break the half-bit RX re-check
            if (done && apb.PWRITE && addr == 3'd4)
                baud <= (apb.PWDATA[15:0] < 16'd4) ? 16'd4 : apb.PWDATA[15:0];
            irq <= (rx_valid & ctrl[2]) | (tx_empty & ctrl[3] & ~tx_busy);
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= apb.PWDATA[7:0];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, tx_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_txd <= 1'b1;
        end else begin
            unique case (tx_state)
                TX_IDLE: if (tx_pop) begin
                    tx_state <= TX_START;
                    tx_sh    <= mem[rd_ptr];
                    uart_txd <= 1'b0;
                    tx_cnt   <= baud - 16'd1;
                end
                TX_START: if (tx_cnt != '0) begin
                    tx_cnt <= tx_cnt - 16'd1;
                end else begin
                    tx_state <= TX_DATA;
                    uart_txd <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_bit   <= '0;
                    tx_cnt   <= baud - 16'd1;
                end
                TX_DATA: if (tx_cnt != '0) begin
                    tx_cnt <= tx_cnt - 16'd1;
                end else begin
                    tx_cnt <= baud - 16'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state <= TX_STOP;
                        uart_txd <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        uart_txd <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                    end
                end
                TX_STOP: if (tx_cnt != '0) begin
                    tx_cnt <= tx_cnt - 16'd1;
                end else if (tx_pop) begin
                    tx_state <= TX_START;
                    tx_sh    <= mem[rd_ptr];
                    uart_txd <= 1'b0;
                    tx_cnt   <= baud - 16'd1;
                end else begin
                    tx_state <= TX_IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else if (!ctrl[1]) begin
            rx_state <= RX_IDLE;
        end else begin
            unique case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_cnt   <= {1'b0, baud[15:1]} - 16'd1;
                end
                RX_START: if (rx_cnt != '0) begin
                    rx_cnt <= rx_cnt - 16'd1;
                end else if (rx_s2) begin
                    rx_state <= RX_IDLE;
                end else begin
                    rx_state <= RX_DATA;
                    rx_bit   <= '0;
                    rx_cnt   <= baud - 16'd1;
                end
                RX_DATA: if (rx_cnt != '0) begin
                    rx_cnt <= rx_cnt - 16'd1;
                end else begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_cnt <= baud - 16'd1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    else rx_bit <= rx_bit + 3'd1;
                end
                RX_STOP: if (rx_cnt != '0) begin
                    rx_cnt <= rx_cnt - 16'd1;
                end else begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // A new byte load takes priority over a same-cycle RXDATA pop
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (rx_stop_hit && !rx_valid) begin
                rx_byte  <= rx_sh;
                rx_valid <= 1'b1;
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end
            if (rx_stop_hit && rx_valid) rx_overrun <= 1'b1;
            else if (clr_ovr)            rx_overrun <= 1'b0;
            if (rx_stop_hit && !rx_s2)   frame_err <= 1'b1;
            else if (clr_fe)             frame_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_apb_uart.sv
// Directed bench for apb_uart: APB timing, TX framing, FIFO limits,
// RX delivery, overrun/frame error, decode errors and async reset.
module tb_apb_uart;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic uart_txd;
    logic uart_rxd = 1'b1;
    logic irq;
    int   total = 0;
    int   bad = 0;

    localparam logic [31:0] A_TX = 32'h00, A_RX = 32'h04, A_ST = 32'h08;
    localparam logic [31:0] A_CT = 32'h0C, A_BD = 32'h10;

    apb_uart_if bus();

    apb_uart #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .apb(bus),
        .uart_txd(uart_txd), .uart_rxd(uart_rxd), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic apb_xfer(input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic er, output int lat);
        @(posedge ACLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = a; bus.PWDATA = wd;
        @(posedge ACLK); #1;
        bus.PENABLE = 1'b1;
        lat = 0;
        do begin
            @(posedge ACLK); #1;
            lat++;
        end while (bus.PREADY !== 1'b1 && lat < 16);
        if (bus.PREADY !== 1'b1) begin
            total++; bad++;
            $display("FAIL apb_timeout addr=%h got_ready=%b want=1", a, bus.PREADY);
        end
        rd = bus.PRDATA;
        er = bus.PSLVERR;
        @(posedge ACLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic er);
        logic [31:0] r;
        int l;
        apb_xfer(1'b1, a, d, r, er, l);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic er);
        int l;
        apb_xfer(1'b0, a, 32'h0, d, er, l);
    endtask

    task automatic tx_capture(input int bound, output logic st,
                              output logic [7:0] b, output logic stp, output bit ok);
        int n;
        n = 0; ok = 0; b = '0; stp = 1'b0; st = 1'b1;
        while (uart_txd !== 1'b0 && n < bound) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (uart_txd !== 1'b0) return;
        ok = 1;
        repeat (4) @(posedge ACLK);
        #1 st = uart_txd;
        for (int i = 0; i < 8; i++) begin
            repeat (8) @(posedge ACLK);
            #1 b[i] = uart_txd;
        end
        repeat (8) @(posedge ACLK);
        #1 stp = uart_txd;
    endtask

    task automatic hold_bit(input logic v);
        uart_rxd = v;
        repeat (8) @(posedge ACLK);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stp);
        @(posedge ACLK); #1;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stp);
        uart_rxd = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic e;
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
        bus.PADDR = '0; bus.PWDATA = '0;
        repeat (3) @(posedge ACLK);
        #1;
        total++;
        if (bus.PRDATA !== 32'h0 || bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0 ||
            uart_txd !== 1'b1 || irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b/%b want=0/0/0/1/0",
                     bus.PRDATA, bus.PREADY, bus.PSLVERR, uart_txd, irq);
        end
        @(negedge ACLK) ARESETn = 1'b1;
        rd(A_ST, d, e);
        total++;
        if (d !== 32'h02 || e !== 1'b0) begin
            bad++; $display("FAIL reset_status got=%h/%b want=02/0", d, e);
        end
        rd(A_BD, d, e);
        total++;
        if (d !== 32'd434) begin
            bad++; $display("FAIL reset_baud got=%0d want=434", d);
        end
        rd(A_CT, d, e);
        total++;
        if (d !== 32'h3) begin
            bad++; $display("FAIL reset_ctrl got=%h want=3", d);
        end
        total++;
        if (uart_txd !== 1'b1) begin
            bad++; $display("FAIL reset_txd got=%b want=1", uart_txd);
        end
    endtask

    task automatic test_tx_frame;
        logic [31:0] r;
        logic e, st, stp;
        logic [7:0] b;
        bit ok;
        int l;
        wr(A_BD, 32'd8, e);
        apb_xfer(1'b1, A_TX, 32'hA5, r, e, l);
        total++;
        if (l !== 1 || e !== 1'b0) begin
            bad++; $display("FAIL tx_ready_latency got=%0d/%b want=1/0", l, e);
        end
        tx_capture(10, st, b, stp, ok);
        total++;
        if (!ok || st !== 1'b0 || b !== 8'hA5 || stp !== 1'b1) begin
            bad++;
            $display("FAIL tx_frame got=%b/%b/%h/%b want=1/0/a5/1", ok, st, b, stp);
        end
        wr(A_TX, 32'h5A, e);
        rd(A_ST, r, e);
        total++;
        if (r !== 32'h12) begin
            bad++; $display("FAIL tx_busy_status got=%h want=12", r);
        end
        repeat (100) @(posedge ACLK);
        rd(A_ST, r, e);
        total++;
        if (r !== 32'h02) begin
            bad++; $display("FAIL tx_idle_status got=%h want=02", r);
        end
    endtask

    task automatic test_fifo;
        logic [31:0] r;
        logic e, st, stp;
        logic [7:0] b;
        bit ok;
        wr(A_CT, 32'h2, e);
        for (int i = 0; i < 9; i++) begin
            wr(A_TX, 32'(i + 1), e);
            total++;
            if (e !== (i == 8)) begin
                bad++; $display("FAIL fifo_push%0d got_err=%b want=%b", i, e, i == 8);
            end
        end
        rd(A_ST, r, e);
        total++;
        if (r !== 32'h01) begin
            bad++; $display("FAIL fifo_full_status got=%h want=01", r);
        end
        wr(A_CT, 32'h3, e);
        for (int i = 0; i < 8; i++) begin
            tx_capture(i == 0 ? 20 : 6, st, b, stp, ok);
            total++;
            if (!ok || st !== 1'b0 || b !== 8'(i + 1) || stp !== 1'b1) begin
                bad++;
                $display("FAIL fifo_frame%0d got=%b/%b/%h/%b want=1/0/%h/1",
                         i, ok, st, b, stp, 8'(i + 1));
            end
        end
        tx_capture(150, st, b, stp, ok);
        total++;
        if (ok) begin
            bad++; $display("FAIL fifo_extra_frame got=%h want=none", b);
        end
        rd(A_ST, r, e);
        total++;
        if (r !== 32'h02) begin
            bad++; $display("FAIL fifo_drained_status got=%h want=02", r);
        end
    endtask

    task automatic test_rx;
        logic [31:0] r;
        logic e;
        wr(A_CT, 32'h7, e);
        rx_send(8'h3C, 1'b1);
        repeat (4) @(posedge ACLK);
        rd(A_ST, r, e);
        total++;
        if (r !== 32'h06) begin
            bad++; $display("FAIL rx_status got=%h want=06", r);
        end
        total++;
        if (irq !== 1'b1) begin
            bad++; $display("FAIL rx_irq got=%b want=1", irq);
        end
        rd(A_RX, r, e);
        total++;
        if (r !== 32'h3C || e !== 1'b0) begin
            bad++; $display("FAIL rx_data got=%h/%b want=3c/0", r, e);
        end
        rd(A_RX, r, e);
        total++;
        if (r !== 32'h0 || e !== 1'b1) begin
            bad++; $display("FAIL rx_empty_read got=%h/%b want=0/1", r, e);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL rx_irq_clear got=%b want=0", irq);
        end
    endtask

    task automatic test_overrun;
        logic [31:0] r;
        logic e;
        wr(A_CT, 32'h3, e);
        rx_send(8'h55, 1'b1);
        rx_send(8'hC3, 1'b0);
        repeat (4) @(posedge ACLK);
        rd(A_ST, r, e);
        total++;
        if (r !== 32'h2E) begin
            bad++; $display("FAIL ovr_status got=%h want=2e", r);
        end
        rd(A_RX, r, e);
        total++;
        if (r !== 32'h55 || e !== 1'b0) begin
            bad++; $display("FAIL ovr_data got=%h/%b want=55/0", r, e);
        end
        wr(A_ST, 32'h28, e);
        rd(A_ST, r, e);
        total++;
        if (r !== 32'h02) begin
            bad++; $display("FAIL ovr_clear got=%h want=02", r);
        end
    endtask

    task automatic test_misc;
        logic [31:0] r;
        logic e;
        rd(32'h1C, r, e);
        total++;
        if (r !== 32'h0 || e !== 1'b1) begin
            bad++; $display("FAIL bad_addr_read got=%h/%b want=0/1", r, e);
        end
        wr(32'h14, 32'hFF, e);
        total++;
        if (e !== 1'b1) begin
            bad++; $display("FAIL bad_addr_write got=%b want=1", e);
        end
        rd(A_TX, r, e);
        total++;
        if (r !== 32'h0 || e !== 1'b0) begin
            bad++; $display("FAIL txdata_read got=%h/%b want=0/0", r, e);
        end
        wr(A_BD, 32'd2, e);
        rd(A_BD, r, e);
        total++;
        if (r !== 32'd4) begin
            bad++; $display("FAIL baud_clamp got=%0d want=4", r);
        end
        wr(A_BD, 32'd8, e);
        wr(A_CT, 32'hB, e);
        repeat (2) @(posedge ACLK);
        #1;
        total++;
        if (irq !== 1'b1) begin
            bad++; $display("FAIL tx_irq got=%b want=1", irq);
        end
        wr(A_CT, 32'h3, e);
        repeat (2) @(posedge ACLK);
        #1;
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL tx_irq_off got=%b want=0", irq);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        logic e;
        int n;
        bit stuck;
        wr(A_TX, 32'h00, e);
        wr(A_TX, 32'h00, e);
        n = 0;
        while (uart_txd !== 1'b0 && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        repeat (20) @(posedge ACLK);
        #1;
        total++;
        if (uart_txd !== 1'b0) begin
            bad++; $display("FAIL mid_frame_low got=%b want=0", uart_txd);
        end
        ARESETn = 1'b0;
        #1;
        total++;
        if (uart_txd !== 1'b1) begin
            bad++; $display("FAIL reset_abort_txd got=%b want=1", uart_txd);
        end
        @(negedge ACLK) ARESETn = 1'b1;
        rd(A_ST, r, e);
        total++;
        if (r !== 32'h02) begin
            bad++; $display("FAIL reset_abort_status got=%h want=02", r);
        end
        rd(A_BD, r, e);
        total++;
        if (r !== 32'd434) begin
            bad++; $display("FAIL reset_abort_baud got=%0d want=434", r);
        end
        stuck = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge ACLK); #1;
            if (uart_txd !== 1'b1) stuck = 1;
        end
        total++;
        if (stuck) begin
            bad++; $display("FAIL reset_abort_idle got=low want=high");
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_fifo();
        test_rx();
        test_overrun();
        test_misc();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
